// File: rtl/ucode_pkg.sv
// Shared field layout, am2910 opcodes and fixed microword builders for the
// writable control store / pipeline register slice.
package ucode_pkg;

   localparam int Y_W      = 12;
   localparam int I_LSB    = 0;
   localparam int I_W      = 4;
   localparam int CCEN_BIT = 4;
   localparam int CI_BIT   = 5;
   localparam int RLD_BIT  = 6;
   localparam int RSVD_BIT = 7;
   localparam int D_LSB    = 8;
   localparam int D_W      = 12;
   localparam int CTRL_LSB = 20;
   localparam int BASE_W   = 20;

   typedef enum logic [3:0] {
      OP_JZ   = 4'd0,
      OP_CJS  = 4'd1,
      OP_JMAP = 4'd2,
      OP_CJP  = 4'd3,
      OP_PUSH = 4'd4,
      OP_JSRP = 4'd5,
      OP_CJV  = 4'd6,
      OP_JRP  = 4'd7,
      OP_RFCT = 4'd8,
      OP_RPCT = 4'd9,
      OP_CRTN = 4'd10,
      OP_CJPP = 4'd11,
      OP_LDCT = 4'd12,
      OP_LOOP = 4'd13,
      OP_CONT = 4'd14,
      OP_TWB  = 4'd15
   } am2910Op_e;

   // Sequencer-facing low 20 bits of a microword; ctrl sits above CTRL_LSB
   // and is zero-extended by the caller for whatever CTRL_W it uses.
   function automatic logic [BASE_W-1:0] buildBase(
      input logic [I_W-1:0] op,
      input logic           ccenBar,
      input logic           ci,
      input logic           rldBar,
      input logic [D_W-1:0] d
   );
      return {d, 1'b0, rldBar, ci, ccenBar, op};
   endfunction

   function automatic logic [BASE_W-1:0] resetBase();
      return buildBase(OP_JZ, 1'b1, 1'b1, 1'b1, '0);
   endfunction

   // CONT with CI=0 makes the sequencer re-emit the same Y next cycle.
   function automatic logic [BASE_W-1:0] freezeBase();
      return buildBase(OP_CONT, 1'b1, 1'b0, 1'b1, '0);
   endfunction

endpackage

// File: rtl/ucs_ram.sv
// Control-store array: asynchronous read, synchronous write, no reset.
module ucs_ram
   import ucode_pkg::*;
#(
   parameter int DEPTH_LOG = 6,
   parameter int WORD_W    = 28
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [DEPTH_LOG-1:0] wr_addr,
   input  logic [WORD_W-1:0]    wr_data,
   input  logic [DEPTH_LOG-1:0] rd_addr,
   output logic [WORD_W-1:0]    rd_data
);

   localparam int DEPTH = 1 << DEPTH_LOG;

   logic [WORD_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/ucode_pipeline.sv
// Writable control store plus microinstruction pipeline register feeding
// the am2910 sequencer, with hold/freeze and out-of-range address detection.
module ucode_pipeline
   import ucode_pkg::*;
#(
   parameter  int DEPTH_LOG = 6,
   parameter  int CTRL_W    = 8,
   localparam int WORD_W    = BASE_W + CTRL_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [Y_W-1:0]       y,
   input  logic                 hold,
   input  logic                 wr_en,
   input  logic [DEPTH_LOG-1:0] wr_addr,
   input  logic [WORD_W-1:0]    wr_data,
   output logic [I_W-1:0]       i_out,
   output logic                 ccen_bar,
   output logic                 ci,
   output logic                 rld_bar,
   output logic [D_W-1:0]       d_out,
   output logic [CTRL_W-1:0]    ctrl,
   output logic [WORD_W-1:0]    pl_word,
   output logic                 range_err
);

   localparam logic [WORD_W-1:0] RESET_WORD  = {{CTRL_W{1'b0}}, resetBase()};
   localparam logic [WORD_W-1:0] FREEZE_WORD = {{CTRL_W{1'b0}}, freezeBase()};

   logic [DEPTH_LOG-1:0] w_rdAddr;
   logic [WORD_W-1:0]    w_ramWord;
   logic [WORD_W-1:0]    w_fetchWord;
   logic                 w_outOfRange;

   logic [WORD_W-1:0]    r_plWord;
   logic                 r_rangeErr;

   assign w_rdAddr = y[DEPTH_LOG-1:0];

   ucs_ram #(
      .DEPTH_LOG (DEPTH_LOG),
      .WORD_W    (WORD_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (w_rdAddr),
      .rd_data (w_ramWord)
   );

   // Shifting rather than slicing keeps this legal when DEPTH_LOG covers all of Y.
   assign w_outOfRange = ((y >> DEPTH_LOG) != '0);

   // A write landing on the address being fetched is forwarded so the
   // pipeline never sees the stale word.
   assign w_fetchWord = (wr_en && (wr_addr == w_rdAddr)) ? wr_data : w_ramWord;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_plWord   <= RESET_WORD;
         r_rangeErr <= 1'b0;
      end else if (hold) begin
         r_plWord   <= FREEZE_WORD;
      end else if (w_outOfRange) begin
         r_plWord   <= FREEZE_WORD;
         r_rangeErr <= 1'b1;
      end else begin
         r_plWord   <= w_fetchWord;
      end
   end

   assign pl_word   = r_plWord;
   assign range_err = r_rangeErr;
   assign i_out     = r_plWord[I_LSB +: I_W];
   assign ccen_bar  = r_plWord[CCEN_BIT];
   assign ci        = r_plWord[CI_BIT];
   assign rld_bar   = r_plWord[RLD_BIT];
   assign d_out     = r_plWord[D_LSB +: D_W];
   assign ctrl      = r_plWord[CTRL_LSB +: CTRL_W];

endmodule

// File: tb/tb_ucode_pipeline.sv
// Directed, table-driven bench for ucode_pipeline at DEPTH_LOG=6, CTRL_W=8.
module tb_ucode_pipeline;

   localparam int WW = 28;

   // Hand-computed fixed words: RESET = JZ,CCEN=1,CI=1,RLD=1 ; FREEZE = CONT,CCEN=1,CI=0,RLD=1
   localparam logic [WW-1:0] RESET_W  = 28'h0000070;
   localparam logic [WW-1:0] FREEZE_W = 28'h000005E;
   localparam logic [WW-1:0] W3       = 28'hA51236E;
   localparam logic [WW-1:0] W7       = 28'h00FFF00;
   localparam logic [WW-1:0] W9       = 28'h3CABC93;
   localparam logic [WW-1:0] W10      = 28'hFFFFFFF;
   localparam logic [WW-1:0] W63      = 28'h1234567;

   logic          clk;
   logic          rst;
   logic [11:0]   y;
   logic          hold;
   logic          wr_en;
   logic [5:0]    wr_addr;
   logic [WW-1:0] wr_data;
   logic [3:0]    i_out;
   logic          ccen_bar;
   logic          ci;
   logic          rld_bar;
   logic [11:0]   d_out;
   logic [7:0]    ctrl;
   logic [WW-1:0] pl_word;
   logic          range_err;

   int passCount;
   int checkCount;

   typedef struct {
      string         name;
      logic          rst;
      logic          hold;
      logic [11:0]   y;
      logic          wrEn;
      logic [5:0]    wrAddr;
      logic [WW-1:0] wrData;
      logic [WW-1:0] expWord;
      logic          expErr;
   } vec_t;

   vec_t vecs[$];

   ucode_pipeline #(
      .DEPTH_LOG (6),
      .CTRL_W    (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .y         (y),
      .hold      (hold),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .i_out     (i_out),
      .ccen_bar  (ccen_bar),
      .ci        (ci),
      .rld_bar   (rld_bar),
      .d_out     (d_out),
      .ctrl      (ctrl),
      .pl_word   (pl_word),
      .range_err (range_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void addVec(string name, logic r, logic h, logic [11:0] ya,
                                  logic we, logic [5:0] wa, logic [WW-1:0] wd,
                                  logic [WW-1:0] ew, logic ee);
      vec_t v;
      v.name = name; v.rst = r; v.hold = h; v.y = ya;
      v.wrEn = we; v.wrAddr = wa; v.wrData = wd;
      v.expWord = ew; v.expErr = ee;
      vecs.push_back(v);
   endfunction

   task automatic checkField(input string name, input logic [WW-1:0] got,
                             input logic [WW-1:0] exp);
      checkCount++;
      if (got === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Compares every output port against fields sliced from the expected word.
   task automatic checkOutput(input string name, input logic [WW-1:0] expWord,
                              input logic expErr);
      checkField({name, ".pl_word"},   pl_word,           expWord);
      checkField({name, ".range_err"}, WW'(range_err),    WW'(expErr));
      checkField({name, ".i_out"},     WW'(i_out),        WW'(expWord[3:0]));
      checkField({name, ".ccen_bar"},  WW'(ccen_bar),     WW'(expWord[4]));
      checkField({name, ".ci"},        WW'(ci),           WW'(expWord[5]));
      checkField({name, ".rld_bar"},   WW'(rld_bar),      WW'(expWord[6]));
      checkField({name, ".d_out"},     WW'(d_out),        WW'(expWord[19:8]));
      checkField({name, ".ctrl"},      WW'(ctrl),         WW'(expWord[27:20]));
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      rst     = v.rst;
      hold    = v.hold;
      y       = v.y;
      wr_en   = v.wrEn;
      wr_addr = v.wrAddr;
      wr_data = v.wrData;
      @(posedge clk);
      #1;
      checkOutput(v.name, v.expWord, v.expErr);
   endtask

   initial begin
      passCount  = 0;
      checkCount = 0;
      rst = 1'b1; hold = 1'b0; y = 12'd5; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

      //      name           rst  hold  y        we   wa     wd     expWord   err
      addVec("reset0",       1, 0, 12'h005, 0, 6'd0,  '0,  RESET_W,  0);
      addVec("reset1",       1, 0, 12'h005, 0, 6'd0,  '0,  RESET_W,  0);
      addVec("rstWrite3",    1, 0, 12'h005, 1, 6'd3,  W3,  RESET_W,  0);
      addVec("fetch3",       0, 0, 12'h003, 0, 6'd0,  '0,  W3,       0);
      addVec("hold1",        0, 1, 12'h003, 0, 6'd0,  '0,  FREEZE_W, 0);
      addVec("hold2",        0, 1, 12'h003, 0, 6'd0,  '0,  FREEZE_W, 0);
      addVec("hold3",        0, 1, 12'h003, 0, 6'd0,  '0,  FREEZE_W, 0);
      addVec("unhold3",      0, 0, 12'h003, 0, 6'd0,  '0,  W3,       0);
      addVec("oor040",       0, 0, 12'h040, 0, 6'd0,  '0,  FREEZE_W, 1);
      addVec("stickyFetch3", 0, 0, 12'h003, 0, 6'd0,  '0,  W3,       1);
      addVec("oorWrite7",    0, 0, 12'h843, 1, 6'd7,  '0,  FREEZE_W, 1);
      addVec("rstClearErr",  1, 0, 12'h003, 0, 6'd0,  '0,  RESET_W,  0);
      addVec("collide7",     0, 0, 12'h007, 1, 6'd7,  W7,  W7,       0);
      addVec("reread7",      0, 0, 12'h007, 0, 6'd0,  '0,  W7,       0);
      addVec("holdWrite9",   0, 1, 12'h009, 1, 6'd9,  W9,  FREEZE_W, 0);
      addVec("fetch9Rsvd",   0, 0, 12'h009, 0, 6'd0,  '0,  W9,       0);
      addVec("noCollide",    0, 0, 12'h009, 1, 6'd10, W10, W9,       0);
      addVec("fetch10",      0, 0, 12'h00A, 1, 6'd63, W63, W10,      0);
      addVec("fetch63Edge",  0, 0, 12'h03F, 0, 6'd0,  '0,  W63,      0);
      addVec("oor800",       0, 0, 12'h800, 0, 6'd0,  '0,  FREEZE_W, 1);
      addVec("prioRst",      1, 1, 12'h800, 0, 6'd0,  '0,  RESET_W,  0);
      addVec("holdOverOor",  0, 1, 12'h800, 0, 6'd0,  '0,  FREEZE_W, 0);

      for (int k = 0; k < vecs.size(); k++) begin
         applyStimulus(vecs[k]);
      end

      // Multi-cycle: y changing between edges must not reach the outputs.
      @(negedge clk);
      rst = 1'b0; hold = 1'b0; y = 12'h003; wr_en = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("regFetch3", W3, 0);
      y = 12'h009;
      #2;
      checkOutput("noCombPath", W3, 0);
      @(posedge clk);
      #1;
      checkOutput("nextFetch9", W9, 0);

      // Multi-cycle: write then hold across the re-emitted address, then release.
      @(negedge clk);
      hold = 1'b1; y = 12'h00A; wr_en = 1'b1; wr_addr = 6'd10; wr_data = W3;
      @(posedge clk);
      #1;
      checkOutput("holdRewrite10", FREEZE_W, 0);
      @(negedge clk);
      wr_en = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("holdAgain", FREEZE_W, 0);
      @(negedge clk);
      hold = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("releaseFetch10", W3, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
